// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Conditions a raw asynchronous input (button, DIP switch, external
//            strobe). The pin passes through a synchroniser chain, and the
//            result is accepted as a new level only after DEBOUNCE_CYCLES
//            consecutive identical samples. The clean level feeds the source
//            side of a downstream edge synchroniser.
// Ports    : clk_i          - single rising-edge clock
//            rst_n_i        - synchronous active-low reset
//            signal_async_i - raw pin, asynchronous to clk_i
//            signal_o       - debounced level (registered)
//            busy_o         - high while a candidate transition is qualifying
//            rise_o         - one-cycle pulse on accepted 0->1 (optional)
//            fall_o         - one-cycle pulse on accepted 1->0 (optional)
// Options  : DEBOUNCE_EDGE_OUT_EN - when defined, rise_o/fall_o are registered
//            edge pulses; otherwise both are tied to 0 and no edge logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,  // 1 .. 2^20
    parameter int SYNC_STAGES     = 2,     // 2 .. 4
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic signal_async_i,
    output logic signal_o,
    output logic busy_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int c_CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_CNT_W     = (c_CNT_W_RAW < 1) ? 1 : c_CNT_W_RAW;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit c_SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_STABLE_L = 2'd0,
        ST_PEND_H   = 2'd1,
        ST_STABLE_H = 2'd2,
        ST_PEND_L   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_signal;
    logic                   r_busy;

    logic w_s;
    logic w_commit_h;
    logic w_commit_l;

    // Only the last synchroniser stage is ever looked at by the filter.
    assign w_s = r_sync[SYNC_STAGES-1];

    // A commit happens either straight from the stable state (single-sample
    // filter) or when the pending count reaches its final sample.
    assign w_commit_h = w_s &&
        (((r_state == ST_STABLE_L) && c_SINGLE) ||
         ((r_state == ST_PEND_H) && (r_cnt == c_CNT_LAST)));
    assign w_commit_l = !w_s &&
        (((r_state == ST_STABLE_H) && c_SINGLE) ||
         ((r_state == ST_PEND_L) && (r_cnt == c_CNT_LAST)));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
            r_state  <= RESET_LEVEL ? ST_STABLE_H : ST_STABLE_L;
            r_signal <= RESET_LEVEL;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], signal_async_i};
            case (r_state)
                ST_STABLE_L: begin
                    if (w_commit_h) begin
                        r_state  <= ST_STABLE_H;
                        r_signal <= 1'b1;
                    end else if (w_s) begin
                        r_state <= ST_PEND_H;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                ST_PEND_H: begin
                    if (!w_s) begin
                        // Glitch: no partial credit is kept.
                        r_state <= ST_STABLE_L;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_commit_h) begin
                        r_state  <= ST_STABLE_H;
                        r_signal <= 1'b1;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_STABLE_H: begin
                    if (w_commit_l) begin
                        r_state  <= ST_STABLE_L;
                        r_signal <= 1'b0;
                    end else if (!w_s) begin
                        r_state <= ST_PEND_L;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                ST_PEND_L: begin
                    if (w_s) begin
                        r_state <= ST_STABLE_H;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_commit_l) begin
                        r_state  <= ST_STABLE_L;
                        r_signal <= 1'b0;
                        r_busy   <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STABLE_L;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign signal_o = r_signal;
    assign busy_o   = r_busy;

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered on the same edge that updates signal_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_commit_h;
            r_fall <= w_commit_l;
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer with
//            DEBOUNCE_CYCLES=4, SYNC_STAGES=2. A second instance with
//            RESET_LEVEL=1 shares the stimulus and is examined during reset.
//            Edge-pulse expectations follow DEBOUNCE_EDGE_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic signal_o, busy_o, rise_o, fall_o;
    logic h_signal_o, h_busy_o, h_rise_o, h_fall_o;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .signal_async_i(din),
        .signal_o      (signal_o),
        .busy_o        (busy_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .RESET_LEVEL    (1'b1)
    ) dut_h (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .signal_async_i(din),
        .signal_o      (h_signal_o),
        .busy_o        (h_busy_o),
        .rise_o        (h_rise_o),
        .fall_o        (h_fall_o)
    );

    // Edge pulses only exist when the option is compiled in.
    function automatic logic edge_exp(input logic v);
`ifdef DEBOUNCE_EDGE_OUT_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic es, input logic eb,
                       input logic er, input logic ef);
        ncmp++;
        assert (signal_o === es) else begin
            nerr++;
            $error("FAIL %s signal_o got %b exp %b", tag, signal_o, es);
        end
        ncmp++;
        assert (busy_o === eb) else begin
            nerr++;
            $error("FAIL %s busy_o got %b exp %b", tag, busy_o, eb);
        end
        ncmp++;
        assert (rise_o === edge_exp(er)) else begin
            nerr++;
            $error("FAIL %s rise_o got %b exp %b", tag, rise_o, edge_exp(er));
        end
        ncmp++;
        assert (fall_o === edge_exp(ef)) else begin
            nerr++;
            $error("FAIL %s fall_o got %b exp %b", tag, fall_o, edge_exp(ef));
        end
    endtask

    task automatic chk_h(input string tag);
        ncmp++;
        assert (h_signal_o === 1'b1) else begin
            nerr++;
            $error("FAIL %s h_signal_o got %b exp 1", tag, h_signal_o);
        end
        ncmp++;
        assert (h_busy_o === 1'b0) else begin
            nerr++;
            $error("FAIL %s h_busy_o got %b exp 0", tag, h_busy_o);
        end
    endtask

    // Hand-computed expectations, index = edge number (1-based, bit 0 unused).
    logic [10:0] busy_clean;   // edges 3..5 busy
    logic [10:0] busy_glitch;  // edges 3..5 busy, then abort at 6
    logic [10:0] busy_bounce;  // 3,5,7,8,9 busy
    logic [3:0]  bounce_in;    // input before edges 1..4, then held 1

    initial begin
        busy_clean  = 11'b00000111000;
        busy_glitch = 11'b00000111000;
        busy_bounce = 11'b01110101000;
        bounce_in   = 4'b0101;     // bit k-1 = value before edge k

        // ---- reset with input high ----
        rst_n = 1'b0;
        din   = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("reset e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
            chk_h($sformatf("reset_h e%0d", e));
        end

        // ---- release with input held high: rise on edge 6 ----
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("rel_rise e%0d", e), (e == 6), busy_clean[e],
                (e == 6), 1'b0);
        end
        tick();
        chk("rel_rise post", 1'b1, 1'b0, 1'b0, 1'b0);

        // ---- clean fall ----
        din = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("fall e%0d", e), (e != 6), busy_clean[e],
                1'b0, (e == 6));
        end
        tick();
        chk("fall post", 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- clean rise from idle ----
        for (int e = 1; e <= 3; e++) tick();
        din = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("rise e%0d", e), (e == 6), busy_clean[e],
                (e == 6), 1'b0);
        end

        // back to low
        din = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        chk("fall2", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 3; e++) tick();

        // ---- glitch: 3 cycles high then low ----
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 3) din = 1'b0;
            chk($sformatf("glitch e%0d", e), 1'b0, busy_glitch[e],
                1'b0, 1'b0);
        end

        // ---- bounce 1,0,1,0,1 then held: rise 6 edges after last change ----
        for (int e = 1; e <= 11; e++) begin
            din = (e <= 4) ? bounce_in[e-1] : 1'b1;
            tick();
            chk($sformatf("bounce e%0d", e), (e >= 10), busy_bounce[e],
                (e == 10), 1'b0);
        end

        // back to low and settle
        din = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        chk("fall3", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 3; e++) tick();

        // ---- reset asserted on edge 4 of a clean rise ----
        din = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        chk("midpend e3", 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midpend rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_h("midpend rst_h");
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("after_rst e%0d", e), (e == 6), busy_clean[e],
                (e == 6), 1'b0);
        end
        tick();
        chk("after_rst post", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Single-clock conditioner for raw asynchronous inputs: buttons, DIP switches, external strobes.
- Synchronises the pin into the clock domain, rejects bounce and glitches, and presents a clean level.
- Sits directly upstream of the edge synchronizer stage: signal_o drives that stage's source-side input, so only qualified transitions generate cross-domain events.

Parameters:
- DebounceCycles, 1000: consecutive stable samples required to accept a new level; legal range 1 to 2^20.
- SyncStages, 2: metastability flops ahead of the filter; legal range 2 to 4.
- ResetLevel, 0: value loaded into the sync chain and signal_o on reset.

Ports:
- clk_i  input  1  single clock. All logic is rising-edge.
- rst_n_i  input  1  synchronous, active-low reset, sampled on rising clk_i.
- signal_async_i  input  1  raw pin, asynchronous to clk_i.
- signal_o  output  1  debounced level, registered.
- busy_o  output  1  high while a candidate transition is being qualified, registered.
- rise_o  output  1  one-cycle pulse on accepted 0->1 transition; see Optional Feature.
- fall_o  output  1  one-cycle pulse on accepted 1->0 transition; see Optional Feature.

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_n_i is synchronous and active-low.
- Reset, while rst_n_i=0 at a clk_i edge:
  - all sync flops <= ResetLevel
  - signal_o <= ResetLevel
  - busy_o <= 0, rise_o/fall_o <= 0, cnt <= 0
  - state <= STABLE_H if ResetLevel=1, else STABLE_L
  - Reset has priority over every other event.
- Sync chain: SyncStages flops in series; s is the last stage. The FSM only ever samples s.
- Counter: cnt, width $clog2(DebounceCycles+1), minimum 1 bit. It never wraps.
- FSM states: STABLE_L, PEND_H, STABLE_H, PEND_L.
- STABLE_L:
  - s=0: stay.
  - s=1 and DebounceCycles=1: go to STABLE_H, signal_o<=1.
  - s=1 otherwise: go to PEND_H, cnt<=1.
- PEND_H:
  - s=0: return to STABLE_L, cnt<=0. signal_o is unchanged.
  - s=1 and cnt=DebounceCycles-1: go to STABLE_H, signal_o<=1, cnt<=0.
  - s=1 otherwise: cnt<=cnt+1.
- STABLE_H and PEND_L mirror STABLE_L and PEND_H with the polarity inverted.
- busy_o = 1 exactly while state is PEND_H or PEND_L. It is registered alongside the state.
- Latency, for an input change that meets setup before edge 1 and is held: signal_o changes on edge SyncStages+DebounceCycles.
  - Example: defaults give 1002 edges.
- Glitch rejection: any return of s to the committed level during PEND aborts the qualification and fully clears cnt. There is no partial credit.
- Bounce: each re-entry to PEND restarts counting at 1.
- Reset mid-PEND: the pending transition is discarded. After release, qualification restarts from the sync chain.

Optional Feature:
- Macro: DEBOUNCE_EDGE_OUT_EN.
- Defined:
  - rise_o=1 for exactly one cycle, on the same edge that signal_o goes 0->1.
  - fall_o is the same for 1->0.
  - Both are registered and both are 0 in all other cycles.
- Undefined:
  - rise_o and fall_o ports remain present and are tied to constant 0.
  - No edge logic is synthesised.

Test Plan (DebounceCycles=4, SyncStages=2, ResetLevel=0 unless stated):
1. rst_n_i=0 for 3 edges with signal_async_i=1 -> signal_o=0, busy_o=0 at every reset edge. After release, signal_o rises on edge 6 counted from release.
2. Clean rise: signal_async_i 0->1 before edge 1, held -> busy_o=1 after edges 3–5, signal_o=1 after edge 6, busy_o=0 after edge 6. Clean fall: the same timing in reverse.
3. Glitch: signal_async_i high for 3 cycles then low -> signal_o stays 0 throughout. busy_o pulses high then returns to 0. No rise_o.
4. Bounce: 1,0,1,0,1 on consecutive cycles, then held 1 -> signal_o rises exactly 6 edges after the final 0->1 change.
5. Reset mid-pending: rst_n_i=0 at edge 4 of a clean rise, input still 1 -> signal_o=0, busy_o=0. After release, the rise needs a full 6 edges. With ResetLevel=1: signal_o=1 during reset.
6. DEBOUNCE_EDGE_OUT_EN defined -> rise_o=1 for one cycle coincident with signal_o 0->1, and fall_o likewise for 1->0. Undefined -> rise_o=fall_o=0 for the whole run.
